// File: rtl/snake_pkg.sv
// snake_pkg: state encoding and score defaults shared by the score path and the game FSM
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam int MAX_SCORE_DEFAULT = 9999;

endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: modulo-N counter with clock enable, sync clear and terminal-count strobe
module snake_tick_gen #(
    parameter int N = 4
) (
    input  logic i_Clk,
    input  logic i_Reset_n,
    input  logic i_En,
    input  logic i_Clr,
    output logic o_Tc
);

    localparam int W = N > 1 ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over enable; wrap to zero after the terminal value
    always_comb cnt_d = i_Clr ? '0 : !i_En ? cnt_q : cnt_q == LAST ? '0 : cnt_q + W'(1);

    // Count register
    always_ff @(posedge i_Clk or negedge i_Reset_n)
        if (!i_Reset_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;

    // Strobe decodes the registered count, so it is glitch-free and cycle-exact
    assign o_Tc = i_En && !i_Clr && cnt_q == LAST;

endmodule

// File: rtl/snake_score_controller.sv
// snake_score_controller: saturating score, session high score, display mode FSM and scan strobe
module snake_score_controller
    import snake_pkg::*;
#(
    parameter int SCORE_WIDTH  = 14,
    parameter int MAX_SCORE    = MAX_SCORE_DEFAULT,
    parameter int BONUS_POINTS = 5,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_TICKS  = 500
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic                   i_GameStart,
    input  logic                   i_GameOver,
    input  logic                   i_FoodEaten,
    input  logic                   i_BonusEaten,
    output logic [SCORE_WIDTH-1:0] o_Score,
    output logic [SCORE_WIDTH-1:0] o_HighScore,
    output logic                   o_ScanTick,
    output logic                   o_ShowHigh,
    output logic                   o_DisplayBlank,
    output logic                   o_NewHigh
);

    localparam int SW = SCORE_WIDTH;
    localparam logic [SW:0]   MAX_WIDE = (SW + 1)'(MAX_SCORE);
    localparam logic [SW-1:0] MAX_S    = SW'(MAX_SCORE);
    localparam logic [SW:0]   BONUS    = (SW + 1)'(BONUS_POINTS);

    state_e        state_q, state_d;
    logic [SW-1:0] score_q, score_d, high_q, high_d, sat;
    logic [SW:0]   sum;
    logic          new_high_q, new_high_d, phase_q, phase_d;
    logic          show_high_q, show_high_d, blank_q, blank_d;
    logic          end_game, new_best, scan_tc, blink_tc;

    snake_tick_gen #(.N(REFRESH_DIV)) u_scan (
        .i_Clk    (i_Clk),
        .i_Reset_n(i_Reset_n),
        .i_En     (1'b1),
        .i_Clr    (1'b0),
        .o_Tc     (scan_tc)
    );

    // Held at zero outside OVER, so every entry starts counting from scratch
    snake_tick_gen #(.N(BLINK_TICKS)) u_blink (
        .i_Clk    (i_Clk),
        .i_Reset_n(i_Reset_n),
        .i_En     (scan_tc),
        .i_Clr    (state_q != OVER),
        .o_Tc     (blink_tc)
    );

    // Next-state logic: scoring, game transitions, high-score capture and display mode
    always_comb begin
        sum         = {1'b0, score_q} + (SW + 1)'(i_FoodEaten) + (i_BonusEaten ? BONUS : '0);
        sat         = sum > MAX_WIDE ? MAX_S : sum[SW-1:0];
        end_game    = state_q == PLAY && i_GameOver && !i_GameStart;
        new_best    = end_game && sat > high_q;
        state_d     = i_GameStart ? PLAY : end_game ? OVER : state_q;
        score_d     = i_GameStart ? '0 : state_q == PLAY ? sat : score_q;
        high_d      = new_best ? sat : high_q;
        new_high_d  = i_GameStart ? 1'b0 : end_game ? new_best : new_high_q;
        phase_d     = state_d != OVER || state_q != OVER ? 1'b0 : phase_q ^ blink_tc;
        show_high_d = state_d == IDLE ? 1'b1 : state_d == PLAY ? 1'b0 : !new_high_d && phase_d;
        blank_d     = state_d == OVER && new_high_d && phase_d;
    end

    // State and registered outputs
    always_ff @(posedge i_Clk or negedge i_Reset_n)
        if (!i_Reset_n) begin
            state_q     <= IDLE;
            score_q     <= '0;
            high_q      <= '0;
            new_high_q  <= 1'b0;
            phase_q     <= 1'b0;
            show_high_q <= 1'b1;
            blank_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            new_high_q  <= new_high_d;
            phase_q     <= phase_d;
            show_high_q <= show_high_d;
            blank_q     <= blank_d;
        end

    assign o_Score        = score_q;
    assign o_HighScore    = high_q;
    assign o_NewHigh      = new_high_q;
    assign o_ShowHigh     = show_high_q;
    assign o_DisplayBlank = blank_q;
    assign o_ScanTick     = scan_tc;

endmodule

// File: tb/tb_snake_score_controller.sv
// tb_snake_score_controller: random and directed stimulus checked against a behavioural score/display model
module tb_snake_score_controller;

    localparam int RD = 4;
    localparam int BT = 2;
    localparam int BP = 5;
    localparam int MX = 9999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0, over = 1'b0, food = 1'b0, bonus = 1'b0;
    logic [13:0] score, high;
    logic        tick, show_high, blank, new_high;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: 0 idle, 1 play, 2 over; m_ot counts scan ticks seen while already in OVER
    int m_mode = 0, m_score = 0, m_high = 0, m_nh = 0, m_cyc = 0, m_ot = 0;

    snake_score_controller #(
        .SCORE_WIDTH (14),
        .MAX_SCORE   (MX),
        .BONUS_POINTS(BP),
        .REFRESH_DIV (RD),
        .BLINK_TICKS (BT)
    ) dut (
        .i_Clk         (clk),
        .i_Reset_n     (rst_n),
        .i_GameStart   (start),
        .i_GameOver    (over),
        .i_FoodEaten   (food),
        .i_BonusEaten  (bonus),
        .o_Score       (score),
        .o_HighScore   (high),
        .o_ScanTick    (tick),
        .o_ShowHigh    (show_high),
        .o_DisplayBlank(blank),
        .o_NewHigh     (new_high)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model advanced on each clock edge from the game rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_score = 0; m_high = 0; m_nh = 0; m_cyc = 0; m_ot = 0;
        end else begin
            if (m_mode == 2 && m_cyc % RD == RD - 1) m_ot++;
            if (start) begin
                m_mode = 1; m_score = 0; m_nh = 0;
            end else if (m_mode == 1) begin
                m_score = m_score + int'(food) + BP * int'(bonus);
                if (m_score > MX) m_score = MX;
                if (over) begin
                    m_mode = 2;
                    m_ot   = 0;
                    if (m_score > m_high) begin m_high = m_score; m_nh = 1; end
                    else m_nh = 0;
                end
            end
            m_cyc++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        int phase;
        phase = (m_ot / BT) % 2;
        chk("score", int'(score), m_score);
        chk("high_score", int'(high), m_high);
        chk("new_high", int'(new_high), m_nh);
        chk("scan_tick", int'(tick), int'(m_cyc % RD == RD - 1));
        chk("show_high", int'(show_high), m_mode == 0 ? 1 : m_mode == 1 ? 0 : (m_nh != 0 ? 0 : phase));
        chk("blank", int'(blank), int'(m_mode == 2 && m_nh != 0 && phase != 0));
    end

    task automatic drive(input logic s, input logic o, input logic f, input logic b);
        {start, over, food, bonus} = {s, o, f, b};
        @(negedge clk);
        {start, over, food, bonus} = 4'b0;
    endtask

    task automatic count_toggles(input bit use_blank, output int n);
        logic prev;
        n    = 0;
        prev = use_blank ? blank : show_high;
        repeat (32) begin
            drive(0, 0, 0, 0);
            if ((use_blank ? blank : show_high) != prev) n++;
            prev = use_blank ? blank : show_high;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_score_lit", int'(score), 0);
        chk("rst_show_lit", int'(show_high), 1);
        chk("rst_tick_lit", int'(tick), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            drive(k == 1, 0, k >= 2 && k <= 4, 0);
            chk("scan_tick_lit", int'(tick), int'(k % 4 == 3));
        end
        chk("three_food_lit", int'(score), 3);
        chk("play_show_lit", int'(show_high), 0);
        chk("play_blank_lit", int'(blank), 0);
        repeat (9) drive(0, 0, 1, 0);
        chk("score12_lit", int'(score), 12);
        drive(0, 1, 0, 1);
        chk("over_bonus_score_lit", int'(score), 17);
        chk("over_bonus_high_lit", int'(high), 17);
        chk("over_bonus_nh_lit", int'(new_high), 1);
        repeat (10) drive(0, 0, 0, 0);
        count_toggles(1, n);
        chk("blank_toggles_lit", n, 4);
        drive(1, 0, 0, 0);
        chk("restart_nh_lit", int'(new_high), 0);
        repeat (3) drive(0, 0, 0, 1);
        repeat (2) drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        chk("tie_nh_lit", int'(new_high), 0);
        chk("tie_high_lit", int'(high), 17);
        repeat (10) drive(0, 0, 0, 0);
        count_toggles(0, n);
        chk("show_toggles_lit", n, 4);
        drive(1, 1, 0, 0);
        chk("start_over_score_lit", int'(score), 0);
        chk("start_over_show_lit", int'(show_high), 0);
        drive(0, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_high_lit", int'(high), 0);
        chk("async_rst_show_lit", int'(show_high), 1);
        chk("async_rst_blank_lit", int'(blank), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        chk("idle_over_show_lit", int'(show_high), 1);
        drive(1, 0, 0, 0);
        repeat (1999) drive(0, 0, 0, 1);
        repeat (2) drive(0, 0, 1, 0);
        chk("sat_pre_lit", int'(score), 9997);
        drive(0, 0, 1, 1);
        chk("sat_lit", int'(score), 9999);
        drive(0, 0, 1, 0);
        chk("sat_hold_lit", int'(score), 9999);
        drive(0, 1, 0, 1);
        chk("sat_high_lit", int'(high), 9999);
        repeat (1500)
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/snake_score_controller.md
# snake_score_controller

Game-side controller for the seven-segment score path. Accumulates score from game-event pulses (food and bonus) into a saturating binary score, and keeps a session high score. Sequences what the scoreboard shows (live score, high score or blank) through an idle/play/over state machine. Generates the digit-scan strobe that paces display refresh.

## Interface
Parameters:
- SCORE_WIDTH, 14, width of score buses; must hold MAX_SCORE.
- MAX_SCORE, 9999, saturation ceiling (four decimal digits).
- BONUS_POINTS, 5, points per bonus event.
- REFRESH_DIV, 50000, clocks per scan tick; must be ≥ 2.
- BLINK_TICKS, 500, scan ticks per blink half-period in OVER; must be ≥ 1.

Ports:
- i_Clk  in  1  system clock.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_GameStart  in  1  one-cycle pulse: start a new game.
- i_GameOver  in  1  one-cycle pulse: snake died.
- i_FoodEaten  in  1  one-cycle pulse: +1 point.
- i_BonusEaten  in  1  one-cycle pulse: +BONUS_POINTS.
- o_Score  out  SCORE_WIDTH  current game score, registered.
- o_HighScore  out  SCORE_WIDTH  best score since reset, registered.
- o_ScanTick  out  1  one-cycle digit-advance strobe to the scoreboard.
- o_ShowHigh  out  1  1 = display o_HighScore, 0 = display o_Score.
- o_DisplayBlank  out  1  1 = blank all digits.
- o_NewHigh  out  1  last finished game set a new high score.

## Operation
- States: IDLE, PLAY, OVER. Reset → IDLE.
- IDLE: o_ShowHigh=1, o_DisplayBlank=0. i_GameStart → PLAY.
- PLAY: o_ShowHigh=0, o_DisplayBlank=0. i_GameStart → PLAY (restart, score cleared). i_GameOver → OVER.
- OVER: i_GameStart → PLAY. Otherwise the state holds, and the blink phase toggles every BLINK_TICKS scan ticks.
  - o_NewHigh=0: o_ShowHigh=phase (alternates score and high score), o_DisplayBlank=0.
  - o_NewHigh=1: o_ShowHigh=0, o_DisplayBlank=phase (blinking score).
- i_GameOver outside PLAY is ignored. i_GameStart has priority over i_GameOver in the same cycle.
- Scoring is active in PLAY only.
  - Per-cycle increment = i_FoodEaten·1 + i_BonusEaten·BONUS_POINTS. Both events in the same cycle are both credited.
  - next = min(o_Score + inc, MAX_SCORE). Compute the sum in SCORE_WIDTH+1 bits; the score never wraps.
- Increment in the same cycle as i_GameOver: credited, and included in the high-score comparison.
- Increment in the same cycle as i_GameStart: dropped; the score clears to 0.
- On the PLAY→OVER transition:
  - If the final score > o_HighScore: o_HighScore ← final score and o_NewHigh ← 1.
  - Otherwise o_NewHigh ← 0.
  - Equality is not a new high.
- On entering PLAY: o_NewHigh ← 0. o_HighScore is retained.
- Scan prescaler: a free-running counter 0..REFRESH_DIV-1, independent of state and events. o_ScanTick=1 exactly when the counter equals REFRESH_DIV-1.
- Blink counter and phase clear to 0 on every entry to OVER.

## Timing
- All outputs registered. Reset values:
  - o_Score=0, o_HighScore=0, o_NewHigh=0.
  - o_ScanTick=0, o_ShowHigh=1, o_DisplayBlank=0.
  - State IDLE; prescaler, blink counter and phase all 0.
- Event pulse in cycle N → o_Score updated at N+1.
- i_GameOver in cycle N → state OVER at N+1. o_HighScore and o_NewHigh are valid at N+1 and reflect any increment in cycle N.
- i_GameStart in cycle N → state PLAY and o_Score=0 at N+1.
- Mode outputs follow the state in the same cycle the state register updates.
- First o_ScanTick after reset release: cycle REFRESH_DIV-1. Period thereafter: REFRESH_DIV.
- OVER, first phase toggle: on the BLINK_TICKS-th scan tick after entry (the entry-cycle tick is not counted).
- Reset asserted mid-game: everything returns to reset values asynchronously, including o_HighScore.

## Structure
- Shared package snake_pkg holds the state encoding constants (IDLE/PLAY/OVER) and the MAX_SCORE default, shared with the game FSM.
- One sub-module, snake_tick_gen: a parameterised modulo-N counter with a terminal-count strobe. It is used for the scan prescaler; the blink counter reuses the same logic, clock-enabled by o_ScanTick.
- The score adder/saturator and state machine live in the top level.

## Test plan
- Reset, then i_GameStart and 3× i_FoodEaten → o_Score=3, o_ShowHigh=0, o_DisplayBlank=0.
- PLAY with score 9997, i_FoodEaten and i_BonusEaten in the same cycle → o_Score=9999 next cycle; a further i_FoodEaten keeps o_Score at 9999.
- Score 12, i_GameOver together with i_BonusEaten → o_Score=17, o_HighScore=17, o_NewHigh=1. o_DisplayBlank toggles every BLINK_TICKS scan ticks (use REFRESH_DIV=4, BLINK_TICKS=2 → 8 clocks).
- Second game ending at 17 → o_NewHigh=0, o_HighScore=17, o_ShowHigh alternating. i_GameStart with i_GameOver in the same cycle → PLAY, o_Score=0.
- i_GameOver in IDLE → no state change. Reset asserted in OVER → all outputs at reset values immediately.
- Prescaler with REFRESH_DIV=4: o_ScanTick high at cycles 3, 7, 11 after reset release, unaffected by game events.
